fpu_issue_ctrl: RTL

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_issue_ctrl_if.sv | 42 ++++
 rtl/fpu_wait_timer.sv | 39 +++
 rtl/fpu_issue_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: data width, opcodes and
// the issue FSM state type.
package fpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FPU_ADD = 3'b000;
  localparam logic [2:0] FPU_SUB = 3'b001;
  localparam logic [2:0] FPU_MUL = 3'b010;
  localparam logic [2:0] FPU_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } issue_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= FPU_DIV;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Bundles the request, execution-unit and writeback channels of the issue
// controller. The slave view belongs to the controller, master to its environment.
interface fpu_issue_ctrl_if;
  import fpu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_rd;

  logic [XLEN-1:0] fpu_operand_a;
  logic [XLEN-1:0] fpu_operand_b;
  logic [2:0]      fpu_operation;
  logic            fpu_start;
  logic [XLEN-1:0] fpu_result;
  logic            fpu_valid;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  logic            busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd,
    input  fpu_result, fpu_valid, wb_ready,
    output req_ready, fpu_operand_a, fpu_operand_b, fpu_operation, fpu_start,
    output wb_valid, wb_rd, wb_data, wb_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd,
    output fpu_result, fpu_valid, wb_ready,
    input  req_ready, fpu_operand_a, fpu_operand_b, fpu_operation, fpu_start,
    input  wb_valid, wb_rd, wb_data, wb_err, busy
  );

endinterface

// File: rtl/fpu_wait_timer.sv
// Counts cycles spent waiting on the execution unit and flags the last
// permitted cycle. Saturates at the expiry value so it can never wrap.
module fpu_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;

  assign expire = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign count  = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with <= only, so every flop sees pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller between the core and a multi-cycle FPU: accepts one request,
// issues it, waits for the result (with timeout) and holds it on writeback.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_LAT        = 1
) (
  input  logic            clk,
  input  logic            reset,
  fpu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  issue_state_e    state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            busy_q, busy_d;
  logic            fpu_start_q, fpu_start_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_err_q, wb_err_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;

  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expire;
  logic             timer_clear;
  logic             timer_enable;
  logic             capture;

  assign timer_clear  = (state_q == ISSUE);
  assign timer_enable = (state_q == WAIT);

  fpu_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .count  (wait_cnt),
    .expire (wait_expire)
  );

  // The first MIN_LAT wait cycles ignore fpu_valid so a level-held valid
  // from a previous result cannot be mistaken for this one.
  assign capture = bus.fpu_valid && (wait_cnt >= CNT_W'(MIN_LAT));

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_a_d = bus.req_a;
          op_b_d = bus.req_b;
          op_d   = bus.req_op;
          rd_d   = bus.req_rd;
          if (op_legal(bus.req_op)) begin
            state_d = ISSUE;
          end else begin
            state_d   = WB;
            wb_data_d = '0;
            wb_err_d  = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (capture) begin
          state_d   = WB;
          wb_data_d = bus.fpu_result;
          wb_err_d  = 1'b0;
        end else if (wait_expire) begin
          state_d   = WB;
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end
      end
      WB: begin
        if (bus.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    fpu_start_d = (state_d == ISSUE);
    wb_valid_d  = (state_d == WB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      fpu_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      fpu_start_q <= fpu_start_d;
      wb_valid_q  <= wb_valid_d;
      wb_err_q    <= wb_err_d;
      wb_data_q   <= wb_data_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.busy          = busy_q;
  assign bus.fpu_start     = fpu_start_q;
  assign bus.fpu_operand_a = op_a_q;
  assign bus.fpu_operand_b = op_b_q;
  assign bus.fpu_operation = op_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_err        = wb_err_q;

endmodule
